// File: rtl/dm_pkg.sv
// Shared constants and types for the MIPS-lite data memory.
package dm_pkg;

   localparam int DM_ADDR_W = 8;
   localparam int DM_DATA_W = 32;
   localparam int DM_DEPTH  = 256;

   typedef logic [DM_ADDR_W-1:0] dm_addr_t;
   typedef logic [DM_DATA_W-1:0] dm_word_t;

endpackage : dm_pkg

// File: rtl/dm_array.sv
// Storage array for data_memory: async clear, one synchronous write port, raw read mux.
// Callers must keep both addresses below DEPTH; no range checking is done here.
module dm_array
   import dm_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W,
   parameter int DEPTH  = DM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Reset wins over a write on the same edge, so that write is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : dm_array

// File: rtl/data_memory.sv
// Word-addressed data memory with range check and read gating.
// Define DM_READ_REG_EN for a registered (1-cycle, read-before-write) dout.
module data_memory
   import dm_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W,
   parameter int DEPTH  = DM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              write,
   input  logic              read,
   output logic [DATA_W-1:0] dout
);

   // One extra bit so DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   logic              in_range;
   logic              we;
   logic [DATA_W-1:0] raw_rdata;
   logic [DATA_W-1:0] dout_d;

   assign in_range = ({1'b0, addr} < DEPTH_C);
   assign we       = write && in_range;

   dm_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .waddr_i (addr),
      .wdata_i (din),
      .raddr_i (addr),
      .rdata_o (raw_rdata)
   );

   // Out-of-range or idle reads return 0 so the raw mux never leaks X.
   always_comb begin
      dout_d = '0;
      if (read && in_range && !rst) begin
         dout_d = raw_rdata;
      end
   end

`ifdef DM_READ_REG_EN
   logic [DATA_W-1:0] dout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;
`else
   assign dout = dout_d;
`endif

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a 256-deep and a 200-deep instance share stimulus.
module tb_data_memory;
   import dm_pkg::*;

   logic     clk;
   logic     rst;
   dm_addr_t addr;
   dm_word_t din;
   logic     write;
   logic     read;
   dm_word_t dout_a;
   dm_word_t dout_b;

   int n_chk;
   int n_fail;

   dm_word_t m_a [256];
   dm_word_t m_b [256];

   dm_word_t q_a [$];
   dm_word_t q_b [$];
   string    q_n [$];

   dm_word_t ea, eb;
   string    nm;

   data_memory #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut_a (
      .clk(clk), .rst(rst), .addr(addr), .din(din),
      .write(write), .read(read), .dout(dout_a)
   );

   data_memory #(.ADDR_W(8), .DATA_W(32), .DEPTH(200)) dut_b (
      .clk(clk), .rst(rst), .addr(addr), .din(din),
      .write(write), .read(read), .dout(dout_b)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic clear_model();
      for (int i = 0; i < 256; i++) begin
         m_a[i] = '0;
         m_b[i] = '0;
      end
   endtask

   task automatic model_update();
      if (write === 1'b1 && rst === 1'b0) begin
         m_a[addr] = din;
         if (addr < 8'd200) m_b[addr] = din;
      end
   endtask

   task automatic push_exp(input string name);
      q_a.push_back((read === 1'b1) ? m_a[addr] : 32'h0);
      q_b.push_back((read === 1'b1 && addr < 8'd200) ? m_b[addr] : 32'h0);
      q_n.push_back(name);
   endtask

   // Drive one access; the expectation is taken from the model before the edge.
   task automatic issue(input logic w, input logic r, input dm_addr_t a,
                        input dm_word_t d, input string name);
      write = w; read = r; addr = a; din = d;
      push_exp(name);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic wr(input dm_addr_t a, input dm_word_t d);
      write = 1'b1; read = 1'b0; addr = a; din = d;
      cycle();
   endtask

   task automatic settle();
`ifdef DM_READ_REG_EN
      @(posedge clk);
      model_update();
      #1;
`else
      #1;
`endif
   endtask

   task automatic post_read();
`ifdef DM_READ_REG_EN
      @(negedge clk);
`else
      cycle();
`endif
   endtask

   task automatic test_reset();
      issue(1'b0, 1'b1, 8'h00, 32'h0, "rst_held_00");
      #1;
      ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
      n_chk += 2;
      if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
      if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      wr(8'h00, 32'h99999999);
      wr(8'hFF, 32'h77777777);
      wr(8'h10, 32'h55555555);
      // Mid-cycle pulse: no clock edge between assertion and the checks.
      write = 1'b0; read = 1'b1; addr = 8'hFF;
      #2 rst = 1'b1;
      clear_model();
      push_exp("rst_high_FF");
      #2;
      for (int k = 0; k < 3; k++) begin
         ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
         n_chk += 2;
         if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
         if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
         if (k == 0) begin
            rst = 1'b0;
            push_exp("rst_done_FF");
            #2;
         end else if (k == 1) begin
            addr = (k == 1) ? 8'h00 : 8'h10;
            push_exp("rst_done_00");
            #2;
         end
      end
      @(negedge clk);
      issue(1'b0, 1'b1, 8'h10, 32'h0, "rst_done_10");
      settle();
      ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
      n_chk += 2;
      if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
      if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
      post_read();
   endtask

   task automatic test_seq_write();
      dm_addr_t order [3];
      order[0] = 8'h01; order[1] = 8'h00; order[2] = 8'h02;
      wr(8'h00, 32'h0000AAFF);
      wr(8'h01, 32'h0000FFAA);
      wr(8'h02, 32'h00002333);
      for (int k = 0; k < 3; k++) begin
         issue(1'b0, 1'b1, order[k], 32'h0, $sformatf("seq_rd_%02h", order[k]));
         settle();
         ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
         n_chk += 2;
         if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
         if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
         post_read();
      end
   endtask

   task automatic test_read_gating();
      issue(1'b0, 1'b0, 8'h01, 32'h0, "gate_read0");
      settle();
      ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
      n_chk += 2;
      if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
      if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
      post_read();
      write = 1'b0; read = 1'b0; addr = 8'h01; din = 32'h12345678;
      cycle();
      issue(1'b0, 1'b1, 8'h01, 32'h0, "gate_write0");
      settle();
      ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
      n_chk += 2;
      if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
      if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
      post_read();
   endtask

   task automatic test_collision();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) issue(1'b1, 1'b1, 8'h05, 32'hDEADBEEF, "coll_before");
         else        issue(1'b0, 1'b1, 8'h05, 32'h0, "coll_after");
         settle();
         ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
         n_chk += 2;
         if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
         if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
         post_read();
      end
   endtask

   task automatic test_boundary();
      dm_addr_t ba [3];
      dm_word_t bd [3];
      ba[0] = 8'hC8; bd[0] = 32'hCAFEBABE;
      ba[1] = 8'hC7; bd[1] = 32'hCAFEBABE;
      ba[2] = 8'hFF; bd[2] = 32'h5A5A1234;
      for (int k = 0; k < 3; k++) begin
         wr(ba[k], bd[k]);
         issue(1'b0, 1'b1, ba[k], 32'h0, $sformatf("bound_%02h", ba[k]));
         settle();
         ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
         n_chk += 2;
         if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
         if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
         post_read();
      end
   endtask

   task automatic test_reset_traffic();
      wr(8'h03, 32'hABCD0003);
      write = 1'b1; read = 1'b1; addr = 8'h03; din = 32'h11111111;
      @(posedge clk);
      rst = 1'b1;
      clear_model();
      push_exp("rst_edge_held");
      #1;
      ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
      n_chk += 2;
      if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
      if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         issue(1'b0, 1'b1, (k == 0) ? 8'h03 : 8'hFF, 32'h0, $sformatf("rst_after_%0d", k));
         settle();
         ea = q_a.pop_front(); eb = q_b.pop_front(); nm = q_n.pop_front();
         n_chk += 2;
         if (dout_a !== ea) begin n_fail++; $display("FAIL %s A: got %h want %h", nm, dout_a, ea); end
         if (dout_b !== eb) begin n_fail++; $display("FAIL %s B: got %h want %h", nm, dout_b, eb); end
         post_read();
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1; write = 1'b0; read = 1'b0; addr = '0; din = '0;
      clear_model();
      @(negedge clk);
      test_reset();
      test_seq_write();
      test_read_gating();
      test_collision();
      test_boundary();
      test_reset_traffic();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_data_memory
